// File: rtl/cordic_pipe_array.sv
// Fully pipelined CORDIC array: one pre-rotation stage followed by STAGES
// shift-add iteration stages. Each sample carries its own mode (rotation or
// vectoring) and valid bit down the pipe; a global enable stalls every register.
module cordic_pipe_array #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned AWIDTH = 20,
  parameter int unsigned STAGES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic                    in_valid,
  input  logic                    mode,
  input  logic signed [WIDTH-1:0] xi,
  input  logic signed [WIDTH-1:0] yi,
  input  logic [AWIDTH-1:0]       zi,
  output logic                    out_valid,
  output logic                    out_mode,
  output logic signed [WIDTH+1:0] xo,
  output logic signed [WIDTH+1:0] yo,
  output logic [AWIDTH-1:0]       zo
);

  // Two guard bits: K*sqrt(2) < 4, so no datapath overflow is possible.
  localparam int unsigned XW = WIDTH + 2;
  // Fraction bits used while building the arctangent table.
  localparam int unsigned FB = 60;

  // round(atan(2^-i) / (2*pi) * 2^AWIDTH). The arctangent is summed as a Taylor
  // series in FB-bit fixed point, then divided by 2*pi held to FB fraction bits
  // (0x6487ED5110B4611A), so the table is exact integer elaboration math.
  function automatic logic [AWIDTH-1:0] atan_turn(input int unsigned i);
    logic [127:0]  acc;
    logic [127:0]  term;
    logic [127:0]  twopi;
    logic [127:0]  scaled;
    int unsigned   sh;
    acc   = '0;
    twopi = 128'h6487ED5110B4611A;
    if (i == 0) begin
      scaled = 128'd1 << (AWIDTH - 3);
    end else begin
      for (int unsigned k = 0; k < 64; k++) begin
        sh = i * (2 * k + 1);
        if (sh <= FB) begin
          term = (128'd1 << (FB - sh)) / 128'(2 * k + 1);
          if ((k % 2) == 0) acc = acc + term;
          else              acc = acc - term;
        end
      end
      scaled = ((acc << AWIDTH) + (twopi >> 1)) / twopi;
    end
    return scaled[AWIDTH-1:0];
  endfunction

  function automatic logic [STAGES*AWIDTH-1:0] atan_table();
    logic [STAGES*AWIDTH-1:0] t;
    t = '0;
    for (int unsigned s = 0; s < STAGES; s++) begin
      t[s*AWIDTH +: AWIDTH] = atan_turn(s);
    end
    return t;
  endfunction

  localparam logic [STAGES*AWIDTH-1:0] ATAN_TBL = atan_table();

  // Index 0 is the pre-rotation register, index s+1 the output of iteration s.
  logic signed [XW-1:0]     x_d [STAGES+1];
  logic signed [XW-1:0]     x_q [STAGES+1];
  logic signed [XW-1:0]     y_d [STAGES+1];
  logic signed [XW-1:0]     y_q [STAGES+1];
  logic [AWIDTH-1:0]        z_d [STAGES+1];
  logic [AWIDTH-1:0]        z_q [STAGES+1];
  logic [STAGES:0]          valid_d;
  logic [STAGES:0]          valid_q;
  logic [STAGES:0]          mode_d;
  logic [STAGES:0]          mode_q;

  logic signed [XW-1:0]     xe;
  logic signed [XW-1:0]     ye;
  logic                     flip;
  logic                     dpos;

  // Next-state for every stage: quadrant fold at entry, then one micro-rotation per stage.
  always_comb begin
    xe   = {{2{xi[WIDTH-1]}}, xi};
    ye   = {{2{yi[WIDTH-1]}}, yi};
    // Rotation folds angles beyond +-90 deg; vectoring folds the left half-plane.
    flip = mode ? xi[WIDTH-1] : (zi[AWIDTH-1] ^ zi[AWIDTH-2]);
    dpos = 1'b0;

    x_d[0]     = flip ? -xe : xe;
    y_d[0]     = flip ? -ye : ye;
    z_d[0]     = flip ? {~zi[AWIDTH-1], zi[AWIDTH-2:0]} : zi;
    valid_d[0] = in_valid;
    mode_d[0]  = mode;

    for (int unsigned s = 0; s < STAGES; s++) begin
      dpos = mode_q[s] ? y_q[s][XW-1] : ~z_q[s][AWIDTH-1];
      if (dpos) begin
        x_d[s+1] = x_q[s] - (y_q[s] >>> s);
        y_d[s+1] = y_q[s] + (x_q[s] >>> s);
        z_d[s+1] = z_q[s] - ATAN_TBL[s*AWIDTH +: AWIDTH];
      end else begin
        x_d[s+1] = x_q[s] + (y_q[s] >>> s);
        y_d[s+1] = y_q[s] - (x_q[s] >>> s);
        z_d[s+1] = z_q[s] + ATAN_TBL[s*AWIDTH +: AWIDTH];
      end
      valid_d[s+1] = valid_q[s];
      mode_d[s+1]  = mode_q[s];
    end
  end

  // Pipeline registers: async clear, advance only while ena is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s <= STAGES; s++) begin
        x_q[s] <= '0;
        y_q[s] <= '0;
        z_q[s] <= '0;
      end
      valid_q <= '0;
      mode_q  <= '0;
    end else if (ena) begin
      for (int unsigned s = 0; s <= STAGES; s++) begin
        x_q[s] <= x_d[s];
        y_q[s] <= y_d[s];
        z_q[s] <= z_d[s];
      end
      valid_q <= valid_d;
      mode_q  <= mode_d;
    end
  end

  assign out_valid = valid_q[STAGES];
  assign out_mode  = mode_q[STAGES];
  assign xo        = x_q[STAGES];
  assign yo        = y_q[STAGES];
  assign zo        = z_q[STAGES];

endmodule

// File: tb/tb_cordic_pipe_array.sv
// Directed bench for cordic_pipe_array: reset state, hand-computed rotation and
// vectoring vectors, a back-to-back mixed-mode stream against a real-number model,
// an enable stall mid-stream and an asynchronous reset with the pipe full.
module tb_cordic_pipe_array;

  localparam int  W     = 16;
  localparam int  AW    = 20;
  localparam int  ST    = 16;
  localparam int  LAT   = ST + 1;
  localparam int  TOLXY = 8;
  localparam int  TOLZ  = 16;
  localparam int  ZMOD  = 1 << AW;
  localparam real PI    = 3.14159265358979323846;
  localparam real KG    = 1.6467602581210656;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic                 ena = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 mode = 1'b0;
  logic signed [W-1:0]  xi = '0;
  logic signed [W-1:0]  yi = '0;
  logic [AW-1:0]        zi = '0;
  logic                 out_valid;
  logic                 out_mode;
  logic signed [W+1:0]  xo;
  logic signed [W+1:0]  yo;
  logic [AW-1:0]        zo;

  cordic_pipe_array #(.WIDTH(W), .AWIDTH(AW), .STAGES(ST)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .mode(mode),
    .xi(xi), .yi(yi), .zi(zi),
    .out_valid(out_valid), .out_mode(out_mode), .xo(xo), .yo(yo), .zo(zo)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit m;
    int ex;
    int ey;
    int ez;
    int t0;
    int st0;
  } exp_t;

  exp_t q[$];
  exp_t last;
  bit   last_valid = 1'b0;
  int   total = 0;
  int   passed = 0;
  int   cyc = 0;
  int   stalls = 0;
  int   popped = 0;

  int rx[10] = '{18000, 12000, -15000, -9000, 20000, 0, -17000, 7000, 14000, -11000};
  int ry[10] = '{-6000, 9000, 5000, -14000, 0, 19000, 8000, -16000, 13000, -11000};
  int vx[10] = '{24000, -20000, -18000, 5000, -25000, 16000, -3000, 21000, -12000, 23000};
  int vy[10] = '{7000, 15000, -17000, -24500, 2000, 19000, 24800, -13000, -22000, 9500};
  int za[10] = '{'h0A3D7, 'h3F120, 'h5C001, 'h7FFFF, 'h80001,
                 'hA1234, 'hC0000, 'hE8765, 'hFFFFF, 'h40001};

  task automatic check_eq(input string tag, input longint got, input longint want);
    total++;
    assert (got === want) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, got, want);
  endtask

  task automatic check_tol(input string tag, input longint got, input longint want, input int tol);
    bit ok;
    ok = ((got - want) <= tol) && ((want - got) <= tol);
    total++;
    assert (ok === 1'b1) passed++;
    else $error("FAIL %s: observed %0d expected %0d (+-%0d)", tag, got, want, tol);
  endtask

  task automatic check_z(input string tag, input int got, input int want);
    int d;
    bit ok;
    d = (got - want) % ZMOD;
    if (d < 0) d += ZMOD;
    if (d >= ZMOD / 2) d -= ZMOD;
    ok = (d <= TOLZ) && (-d <= TOLZ);
    total++;
    assert (ok === 1'b1) passed++;
    else $error("FAIL %s: observed %0d expected %0d mod 2^%0d (+-%0d)", tag, got, want % ZMOD, AW, TOLZ);
  endtask

  function automatic int rnd(input real v);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  task automatic model(input bit m, input int x, input int y, input int z,
                       output int ex, output int ey, output int ez);
    real th;
    real zs;
    if (!m) begin
      zs = (z >= ZMOD / 2) ? real'(z - ZMOD) : real'(z);
      th = zs * 2.0 * PI / real'(ZMOD);
      ex = rnd(KG * (real'(x) * $cos(th) - real'(y) * $sin(th)));
      ey = rnd(KG * (real'(x) * $sin(th) + real'(y) * $cos(th)));
      ez = 0;
    end else begin
      ex = rnd(KG * $sqrt(real'(x) * real'(x) + real'(y) * real'(y)));
      ey = 0;
      ez = z + rnd($atan2(real'(y), real'(x)) * real'(ZMOD) / (2.0 * PI));
    end
  endtask

  // One clock; outputs are inspected 1 time unit after the rising edge.
  task automatic tick();
    bit   en_at_edge;
    exp_t e;
    en_at_edge = ena;
    @(posedge clk);
    #1;
    cyc++;
    if (!en_at_edge) begin
      stalls++;
      check_eq("stall_hold_valid", out_valid, last_valid);
      if (last_valid) check_tol("stall_hold_xo", xo, last.ex, TOLXY);
    end else if (out_valid === 1'b1) begin
      if (q.size() == 0) begin
        check_eq("spurious_valid", out_valid, 0);
      end else begin
        e = q.pop_front();
        popped++;
        check_eq("out_mode", out_mode, e.m);
        check_tol("xo", xo, e.ex, TOLXY);
        check_tol("yo", yo, e.ey, TOLXY);
        check_z("zo", int'(zo), e.ez);
        check_eq("latency", cyc - e.t0, LAT + (stalls - e.st0));
        last       = e;
        last_valid = 1'b1;
      end
    end else begin
      last_valid = 1'b0;
      if (q.size() > 0 && (cyc - q[0].t0) > LAT + (stalls - q[0].st0)) begin
        check_eq("missing_output", out_valid, 1);
        void'(q.pop_front());
      end
    end
  endtask

  task automatic send(input bit m, input int x, input int y, input int z,
                      input int ex, input int ey, input int ez);
    exp_t e;
    mode     = m;
    xi       = 16'(x);
    yi       = 16'(y);
    zi       = 20'(z);
    in_valid = 1'b1;
    if (ena) begin
      e.m = m; e.ex = ex; e.ey = ey; e.ez = ez; e.t0 = cyc; e.st0 = stalls;
      q.push_back(e);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_model(input bit m, input int x, input int y, input int z);
    int ex;
    int ey;
    int ez;
    model(m, x, y, z, ex, ey, ez);
    send(m, x, y, z, ex, ey, ez);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && q.size() > 0; i++) tick();
    check_eq("drain_empty", q.size(), 0);
  endtask

  task automatic send_stream(input int i);
    int k;
    k = i % 10;
    if ((i % 2) == 0) send_model(1'b0, rx[k], ry[k], za[k]);
    else              send_model(1'b1, vx[k], vy[k], za[9-k]);
  endtask

  initial begin
    int p0;

    // Reset state
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_mode", out_mode, 0);
    check_eq("rst_xo", xo, 0);
    check_eq("rst_yo", yo, 0);
    check_eq("rst_zo", zo, 0);
    rst_n = 1'b1;
    tick();

    // Hand-computed vectors
    send(1'b0, 10000, 0, 0, 16468, 0, 0);              drain();
    send(1'b0, 10000, 0, 'h40000, 0, 16468, 0);        drain();
    send(1'b0, 10000, 0, 'hC0000, 0, -16468, 0);       drain();
    send(1'b0, 10000, 0, 'h80000, -16468, 0, 0);       drain();
    send(1'b1, 10000, 10000, 0, 23289, 0, 131072);     drain();
    send(1'b1, -10000, 0, 0, 16468, 0, 'h80000);       drain();
    send(1'b1, 0, 0, 'h12345, 0, 0, 'h12345 + 290925); drain();
    send(1'b1, -32768, -32768, 0, 76312, 0, 'hA0000);  drain();

    // 20 back-to-back samples, alternating mode
    p0 = popped;
    for (int i = 0; i < 20; i++) send_stream(i);
    drain();
    check_eq("stream_count", popped - p0, 20);

    // Enable low for 5 clocks mid-stream; inputs offered during the stall are ignored
    p0 = popped;
    for (int i = 0; i < 8; i++) send_stream(i + 3);
    ena = 1'b0;
    for (int j = 0; j < 5; j++) begin
      in_valid = 1'b1;
      mode     = 1'b0;
      xi       = 16'sd1234;
      yi       = -16'sd4321;
      zi       = 20'h1ABCD;
      tick();
    end
    in_valid = 1'b0;
    ena      = 1'b1;
    for (int i = 8; i < 16; i++) send_stream(i + 3);
    drain();
    check_eq("stall_count", popped - p0, 16);

    // Asynchronous reset with the pipeline full
    for (int i = 0; i < 17; i++) send_stream(i + 1);
    rst_n = 1'b0;
    #2;
    check_eq("rst_async_valid", out_valid, 0);
    check_eq("rst_async_xo", xo, 0);
    check_eq("rst_async_zo", zo, 0);
    q.delete();
    last_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (20) tick();
    p0 = popped;
    send(1'b0, 10000, 0, 0, 16468, 0, 0);
    drain();
    check_eq("post_rst_count", popped - p0, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
